// File: rtl/pa_out_sched.sv
// Output scheduler: pops one word from datapath F0 into A0, then holds it for max(dwell,1) cycles.
// Sticky underrun flags a word that was due while F0 was empty.
module pa_out_sched #(
    parameter int unsigned DWELL_W = 8,
    parameter logic [2:0]  CS_LOAD = 3'b000,
    parameter logic [2:0]  CS_HOLD = 3'b001
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               f0_empty,
    input  logic               clr_underrun,
    output logic [2:0]         cs_addr,
    output logic               load,
    output logic               busy,
    output logic               underrun,
    output logic [7:0]         word_cnt
);

    typedef enum logic [1:0] {StIdle, StLoad, StHold, StWait} state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [DWELL_W-1:0] r_hold_cnt;
    logic [DWELL_W-1:0] w_dwell_eff;
    logic               w_hold_last;
    logic               w_set_underrun;
    logic               r_underrun;
    logic [7:0]         r_word_cnt;

    assign w_dwell_eff    = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign w_hold_last    = (r_hold_cnt <= DWELL_W'(1));
    assign w_set_underrun = (r_state == StHold) && w_hold_last && en && f0_empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: if (en && !f0_empty) w_state_nxt = StLoad;
            StLoad: w_state_nxt = StHold;
            StHold: begin
                if (w_hold_last) begin
                    if (!en)           w_state_nxt = StIdle;
                    else if (f0_empty) w_state_nxt = StWait;
                    else               w_state_nxt = StLoad;
                end
            end
            StWait: begin
                if (!en)            w_state_nxt = StIdle;
                else if (!f0_empty) w_state_nxt = StLoad;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Dwell is captured only in LOAD so later changes cannot disturb a hold in progress.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_cnt <= '0;
            r_word_cnt <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (r_state == StLoad) begin
                r_hold_cnt <= w_dwell_eff;
                r_word_cnt <= r_word_cnt + 8'd1;
            end else if (r_state == StHold && r_hold_cnt != '0) begin
                r_hold_cnt <= r_hold_cnt - DWELL_W'(1);
            end
            if (w_set_underrun) begin
                r_underrun <= 1'b1;
            end else if (clr_underrun) begin
                r_underrun <= 1'b0;
            end
        end
    end

    // Outputs depend on registered state only, so cs_addr has no input-to-output path.
    always_comb begin
        load     = (r_state == StLoad);
        busy     = (r_state != StIdle);
        cs_addr  = (r_state == StLoad) ? CS_LOAD : CS_HOLD;
        underrun = r_underrun;
        word_cnt = r_word_cnt;
    end

endmodule

// File: tb/tb_pa_out_sched.sv
// Bench for pa_out_sched: scripted vector table, F0-driven scenarios and a randomized
// run against a cycle-level behavioural model of the scheduler.
module tb_pa_out_sched;

    localparam logic [2:0] CsLoad = 3'b000;
    localparam logic [2:0] CsHold = 3'b001;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       en;
    logic [7:0] dwell;
    logic       f0_empty;
    logic       clr_underrun;
    logic [2:0] cs_addr;
    logic       load;
    logic       busy;
    logic       underrun;
    logic [7:0] word_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    pa_out_sched #(
        .DWELL_W(8),
        .CS_LOAD(CsLoad),
        .CS_HOLD(CsHold)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .en          (en),
        .dwell       (dwell),
        .f0_empty    (f0_empty),
        .clr_underrun(clr_underrun),
        .cs_addr     (cs_addr),
        .load        (load),
        .busy        (busy),
        .underrun    (underrun),
        .word_cnt    (word_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       en;
        logic       emp;
        logic       clr;
        logic [7:0] dw;
        logic       e_load;
        logic       e_busy;
        logic       e_und;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        en           = 1'b0;
        f0_empty     = 1'b1;
        clr_underrun = 1'b0;
        dwell        = 8'd0;
        reset_n      = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
    endtask

    // Runs with a simple F0 word count; pops on each observed LOAD and checks load spacing.
    task automatic run_fifo(input int words, input int dwell_v, input int cycles,
                            output int nloads, output int bad_period);
        int fifo   = words;
        int last_t = -1;
        int period = ((dwell_v == 0) ? 1 : dwell_v) + 1;
        nloads     = 0;
        bad_period = 0;
        dwell      = 8'(dwell_v);
        en         = 1'b1;
        for (int t = 1; t <= cycles; t++) begin
            f0_empty = (fifo == 0);
            step();
            if (load) begin
                if (last_t >= 0 && t - last_t != period) bad_period++;
                last_t = t;
                nloads++;
                if (fifo > 0) fifo--;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1 (simulation did not complete)");
        $fatal(1, "timeout");
    end

    initial begin
        int nl, bp, holds, extra_loads, seen;
        bit m_busy, m_load, m_und, set_u;
        int m_left, m_cnt;

        tbl[0]  = '{1, 0, 0, 1, 1, 1, 0, 0};
        tbl[1]  = '{1, 0, 0, 1, 0, 1, 0, 1};
        tbl[2]  = '{1, 1, 0, 1, 0, 1, 1, 1};
        tbl[3]  = '{1, 1, 1, 1, 0, 1, 0, 1};
        tbl[4]  = '{1, 0, 0, 1, 1, 1, 0, 1};
        tbl[5]  = '{0, 0, 0, 2, 0, 1, 0, 2};
        tbl[6]  = '{0, 0, 0, 0, 0, 1, 0, 2};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 2};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 2};
        tbl[9]  = '{1, 1, 0, 0, 0, 0, 0, 2};
        tbl[10] = '{1, 0, 0, 0, 1, 1, 0, 2};
        tbl[11] = '{1, 1, 0, 0, 0, 1, 0, 3};
        tbl[12] = '{1, 1, 0, 0, 0, 1, 1, 3};
        tbl[13] = '{0, 1, 0, 0, 0, 0, 1, 3};

        reset_n = 1'b1;
        en = 1'b0; f0_empty = 1'b1; clr_underrun = 1'b0; dwell = 8'd0;
        #2 reset_n = 1'b0;
        #1;
        chk("reset_load", load, 0);
        chk("reset_busy", busy, 0);
        chk("reset_cs_addr", cs_addr, CsHold);
        chk("reset_underrun", underrun, 0);
        chk("reset_word_cnt", word_cnt, 0);

        // Scripted vectors
        do_reset();
        foreach (tbl[i]) begin
            en = tbl[i].en; f0_empty = tbl[i].emp; clr_underrun = tbl[i].clr; dwell = tbl[i].dw;
            step();
            chk($sformatf("tbl%0d_load", i), load, tbl[i].e_load);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_cs_addr", i), cs_addr, tbl[i].e_load ? CsLoad : CsHold);
            chk($sformatf("tbl%0d_underrun", i), underrun, tbl[i].e_und);
            chk($sformatf("tbl%0d_word_cnt", i), word_cnt, tbl[i].e_cnt);
        end
        clr_underrun = 1'b0;

        // Four words at dwell 3
        do_reset();
        run_fifo(4, 3, 30, nl, bp);
        chk("d3_loads", nl, 4);
        chk("d3_period", bp, 0);
        chk("d3_word_cnt", word_cnt, 4);
        chk("d3_wait_busy", busy, 1);
        chk("d3_underrun", underrun, 1);

        // One word at dwell 0: a single pop then WAIT
        do_reset();
        run_fifo(1, 0, 10, nl, bp);
        chk("d0_loads", nl, 1);
        chk("d0_word_cnt", word_cnt, 1);
        chk("d0_wait_busy", busy, 1);
        chk("d0_underrun", underrun, 1);

        // Set and clear in the same cycle: set wins, a later clear takes effect
        f0_empty = 1'b0;
        step();
        chk("sc_load", load, 1);
        f0_empty = 1'b1;
        step();
        clr_underrun = 1'b1;
        step();
        chk("sc_set_wins", underrun, 1);
        step();
        chk("sc_clear_later", underrun, 0);
        clr_underrun = 1'b0;

        // en dropped in the second HOLD cycle with dwell 5; dwell change mid-hold ignored
        do_reset();
        dwell = 8'd5; en = 1'b1; f0_empty = 1'b0;
        step();
        chk("abort_load", load, 1);
        holds = 0; extra_loads = 0;
        step();
        if (busy && !load) holds++;
        step();
        if (busy && !load) holds++;
        en = 1'b0; dwell = 8'd1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (load) extra_loads++;
            if (busy && !load) holds++;
        end
        chk("abort_hold_cycles", holds, 5);
        chk("abort_no_load", extra_loads, 0);
        chk("abort_idle_busy", busy, 0);

        // Async reset mid-HOLD with word_cnt 7
        do_reset();
        run_fifo(20, 3, 26, nl, bp);
        chk("pre_rst_word_cnt", word_cnt, 7);
        chk("pre_rst_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_load", load, 0);
        chk("async_busy", busy, 0);
        chk("async_cs_addr", cs_addr, CsHold);
        chk("async_underrun", underrun, 0);
        chk("async_word_cnt", word_cnt, 0);
        @(negedge clock);
        reset_n = 1'b1; en = 1'b1; f0_empty = 1'b0;
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (load) seen = 1;
        end
        chk("post_rst_load", seen, 1);

        // 257 words at dwell 1: wrap and steady period
        do_reset();
        run_fifo(257, 1, 530, nl, bp);
        chk("wrap_loads", nl, 257);
        chk("wrap_period", bp, 0);
        chk("wrap_word_cnt", word_cnt, 1);

        // Randomized run against the behavioural model
        do_reset();
        m_busy = 0; m_load = 0; m_und = 0; m_left = 0; m_cnt = 0;
        for (int c = 0; c < 2000; c++) begin
            en           = ($urandom_range(99) < 85);
            f0_empty     = ($urandom_range(99) < 40);
            clr_underrun = ($urandom_range(99) < 10);
            dwell        = 8'($urandom_range(4));
            set_u = 0;
            if (m_load) begin
                m_load = 0;
                m_left = (dwell == 0) ? 1 : int'(dwell);
                m_cnt  = (m_cnt + 1) % 256;
            end else if (!m_busy) begin
                if (en && !f0_empty) begin m_busy = 1; m_load = 1; end
            end else if (m_left > 1) begin
                m_left--;
            end else begin
                if (m_left == 1 && en && f0_empty) set_u = 1;
                m_left = 0;
                if (!en)            m_busy = 0;
                else if (!f0_empty) m_load = 1;
            end
            m_und = set_u ? 1'b1 : (clr_underrun ? 1'b0 : m_und);
            step();
            chk("rnd_load", load, m_load);
            chk("rnd_busy", busy, m_busy);
            chk("rnd_cs_addr", cs_addr, m_load ? CsLoad : CsHold);
            chk("rnd_underrun", underrun, m_und);
            chk("rnd_word_cnt", word_cnt, m_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pa_out_sched.md
PA_OUT_SCHED -- requirements
Module: pa_out_sched

Interface
REQ-001 Parameter DWELL_W, default 8, width of the dwell count.
REQ-002 Parameter CS_LOAD, default 3'b000, datapath cs_addr selecting the F0-to-A0 load.
REQ-003 Parameter CS_HOLD, default 3'b001, datapath cs_addr selecting no register update.
REQ-004 clock  input  1  sole clock, rising edge; also drives the datapath.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  run enable; synchronous level.
REQ-007 dwell  input  DWELL_W  hold cycles per word; sampled only in LOAD.
REQ-008 f0_empty  input  1  datapath F0 empty status, 1 = empty.
REQ-009 clr_underrun  input  1  synchronous clear of the underrun flag.
REQ-010 cs_addr  output  3  datapath configuration address.
REQ-011 load  output  1  high exactly in cycles where cs_addr = CS_LOAD.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 underrun  output  1  sticky flag, F0 was empty when the next word was due.
REQ-014 word_cnt  output  8  count of LOAD cycles, modulo 256.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, HOLD and WAIT, registered on clock.
REQ-016 cs_addr SHALL be CS_LOAD in LOAD and CS_HOLD in all other states, decoded from the state register with no glitch path from inputs.
REQ-017 IDLE: if en=1 and f0_empty=0 go to LOAD, else stay.
REQ-018 LOAD SHALL last exactly one cycle, load the hold counter with max(dwell,1), and increment word_cnt; next state is always HOLD.
REQ-019 HOLD SHALL decrement the counter each cycle and last exactly max(dwell,1) cycles, so F0 status has settled before the next decision.
REQ-020 At the last HOLD cycle: en=0 -> IDLE; en=1 and f0_empty=0 -> LOAD; en=1 and f0_empty=1 -> WAIT.
REQ-021 With continuous data and en=1, the load period SHALL be max(dwell,1)+1 cycles.
REQ-022 en deasserted during LOAD or HOLD SHALL NOT abort; the current hold completes, then IDLE.
REQ-023 WAIT: en=0 -> IDLE; else f0_empty=0 -> LOAD; else stay.
REQ-024 underrun SHALL set on the HOLD-to-WAIT transition; clr_underrun=1 clears it next cycle; simultaneous set and clear leaves it set.
REQ-025 dwell changes outside LOAD SHALL NOT affect the hold in progress.
REQ-026 word_cnt SHALL wrap from 255 to 0 without a flag.

Reset
REQ-027 reset_n=0 SHALL immediately force state IDLE, cs_addr=CS_HOLD, load=0, busy=0, underrun=0, word_cnt=0, hold counter=0.
REQ-028 Reset asserted mid-LOAD or mid-HOLD SHALL abandon the sequence; after release the block restarts from IDLE per REQ-017.

Verification
REQ-029 dwell=3, en=1, F0 holds 4 words -> load pulses at cycles t, t+4, t+8, t+12; word_cnt=4; then WAIT, underrun=1.
REQ-030 dwell=0, F0 holds 1 word -> one LOAD, one HOLD cycle, then WAIT; exactly one pop, no double pop.
REQ-031 en dropped in second HOLD cycle with dwell=5 -> HOLD runs all 5 cycles, then IDLE, busy=0, no further load.
REQ-032 underrun set and clr_underrun=1 in the same cycle as a new HOLD-to-WAIT transition -> underrun stays 1; clr on a later cycle -> 0.
REQ-033 reset_n pulsed low during HOLD with word_cnt=7 -> all outputs at reset values asynchronously; after release with data present, LOAD on the second clock edge.
REQ-034 257 words at dwell=1 -> word_cnt=1 at end, load period 2 cycles throughout.
